// File: rtl/rf_arb_pkg.sv
// Shared constants and the grant-selection helper for the register-file write arbiter.
// Grant policy is chosen in rf_write_arbiter via RF_ARB_RR_EN.
package rf_arb_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam int NREQ       = 2;
    localparam int ZERO_REG   = 0;

    // When both slots are full: round-robin picks the requester that did not win last,
    // otherwise requester 0 wins. A single full slot is always the one granted.
    function automatic logic [NREQ-1:0] arb_pick(input logic [NREQ-1:0] full,
                                                 input logic            rr,
                                                 input logic            last);
        if (&full) arb_pick = (rr && !last) ? 2'b10 : 2'b01;
        else       arb_pick = full;
    endfunction

endpackage

// File: rtl/rf_arb_slot.sv
// One pending-write slot: holds a single accepted write until the arbiter grants it.
// Writes aimed at the hard-wired zero register are accepted but never stored.
module rf_arb_slot
    import rf_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              vld_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              gnt,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              rdy
);

    logic              full_q, full_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    // A granted slot drains on this edge, so it can take a new write in the same cycle.
    assign rdy  = (!full_q || gnt) && !clr;
    assign full = full_q;
    assign addr = addr_q;
    assign data = data_q;

    always_comb begin
        full_d = full_q;
        addr_d = addr_q;
        data_d = data_q;
        if (gnt) full_d = 1'b0;
        if (vld_in && rdy) begin
            full_d = (addr_in != ADDR_W'(ZERO_REG));
            addr_d = addr_in;
            data_d = data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            full_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Two-requester write arbiter feeding a single register-file write port, one write per cycle.
// Define RF_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (requester 0).
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              V0,
    input  logic [ADDR_W-1:0] A0,
    input  logic [DATA_W-1:0] D0,
    output logic              R0,
    input  logic              V1,
    input  logic [ADDR_W-1:0] A1,
    input  logic [DATA_W-1:0] D1,
    output logic              R1,
    output logic [ADDR_W-1:0] Wr,
    output logic [DATA_W-1:0] D,
    output logic              We,
    output logic [1:0]        Gnt,
    output logic              Busy
);

    logic [NREQ-1:0]             req_vld, slot_full, slot_gnt, slot_rdy;
    logic [NREQ-1:0][ADDR_W-1:0] req_addr, slot_addr;
    logic [NREQ-1:0][DATA_W-1:0] req_data, slot_data;

    assign req_vld  = {V1, V0};
    assign req_addr = {A1, A0};
    assign req_data = {D1, D0};

    for (genvar i = 0; i < NREQ; i++) begin : g_slot
        rf_arb_slot #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) u_slot (
            .clk     (Clk),
            .clr     (Clr),
            .vld_in  (req_vld[i]),
            .addr_in (req_addr[i]),
            .data_in (req_data[i]),
            .gnt     (slot_gnt[i]),
            .full    (slot_full[i]),
            .addr    (slot_addr[i]),
            .data    (slot_data[i]),
            .rdy     (slot_rdy[i])
        );
    end

    assign R0   = slot_rdy[0];
    assign R1   = slot_rdy[1];
    assign Busy = |slot_full;

`ifdef RF_ARB_RR_EN
    // last_q is the index of the most recent winner; reset to 1 so requester 0 wins first.
    logic last_q, last_d;

    assign slot_gnt = arb_pick(slot_full, 1'b1, last_q);

    always_comb begin
        last_d = last_q;
        if (|slot_gnt) last_d = slot_gnt[1];
    end

    always_ff @(posedge Clk) begin
        if (Clr) last_q <= 1'b1;
        else     last_q <= last_d;
    end
`else
    assign slot_gnt = arb_pick(slot_full, 1'b0, 1'b1);
`endif

    logic              we_q, we_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [ADDR_W-1:0] wr_q, wr_d;
    logic [DATA_W-1:0] dat_q, dat_d;

    // Wr/D keep their last value on idle cycles; only We/Gnt drop.
    always_comb begin
        we_d  = |slot_gnt;
        gnt_d = slot_gnt;
        wr_d  = wr_q;
        dat_d = dat_q;
        if (slot_gnt[0]) begin
            wr_d  = slot_addr[0];
            dat_d = slot_data[0];
        end else if (slot_gnt[1]) begin
            wr_d  = slot_addr[1];
            dat_d = slot_data[1];
        end
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            we_q  <= 1'b0;
            gnt_q <= '0;
            wr_q  <= '0;
            dat_q <= '0;
        end else begin
            we_q  <= we_d;
            gnt_q <= gnt_d;
            wr_q  <= wr_d;
            dat_q <= dat_d;
        end
    end

    assign We  = we_q;
    assign Gnt = gnt_q;
    assign Wr  = wr_q;
    assign D   = dat_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed plus randomized bench for rf_write_arbiter against a pending-write reference model.
// Expectations follow RF_ARB_RR_EN the same way the design does.
module tb_rf_write_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
`ifdef RF_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Clr, V0, V1, R0, R1, We, Busy;
    logic [AW-1:0] A0, A1, Wr;
    logic [DW-1:0] D0, D1, D;
    logic [1:0]    Gnt;

    always #5 Clk = ~Clk;

    rf_write_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .Clk(Clk), .Clr(Clr),
        .V0(V0), .A0(A0), .D0(D0), .R0(R0),
        .V1(V1), .A1(A1), .D1(D1), .R1(R1),
        .Wr(Wr), .D(D), .We(We), .Gnt(Gnt), .Busy(Busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference: each requester owns at most one pending write; the write port shows
    // whichever pending write won the cycle before.
    typedef struct {
        bit          v;
        int          addr;
        logic [31:0] data;
    } pend_t;

    pend_t       pend [2];
    int          last_win;
    bit          e_we;
    int          e_wr;
    logic [31:0] e_d;
    int          e_gnt;
    logic [31:0] exp_rf [32];
    logic [31:0] dut_rf [32];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int winner();
        if (pend[0].v && pend[1].v) return RR ? 1 - last_win : 0;
        if (pend[0].v) return 0;
        if (pend[1].v) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        pend[0].v = 0; pend[1].v = 0;
        last_win = 1;
        e_we = 0; e_gnt = 0; e_wr = 0; e_d = '0;
    endtask

    // Apply one cycle of inputs (called at a falling edge), check ready before the
    // rising edge and the registered port after it.
    task automatic cycle(input bit clr, input bit v0, input int a0, input logic [31:0] d0,
                         input bit v1, input int a1, input logic [31:0] d1);
        int          w;
        bit          rdy [2];
        bit          vv [2];
        int          aa [2];
        logic [31:0] dd [2];
        vv[0] = v0; aa[0] = a0; dd[0] = d0;
        vv[1] = v1; aa[1] = a1; dd[1] = d1;
        Clr = clr; V0 = v0; A0 = a0[AW-1:0]; D0 = d0;
        V1 = v1; A1 = a1[AW-1:0]; D1 = d1;
        #1;
        w = winner();
        for (int n = 0; n < 2; n++) rdy[n] = !clr && (!pend[n].v || w == n);
        chk("R0", R0, rdy[0]);
        chk("R1", R1, rdy[1]);
        if (clr) begin
            model_reset();
        end else begin
            if (w >= 0) begin
                e_we = 1; e_wr = pend[w].addr; e_d = pend[w].data; e_gnt = 1 << w;
                last_win = w;
                pend[w].v = 0;
                exp_rf[e_wr] = e_d;
            end else begin
                e_we = 0; e_gnt = 0;
            end
            for (int n = 0; n < 2; n++)
                if (vv[n] && rdy[n] && aa[n] != 0) begin
                    pend[n].v = 1; pend[n].addr = aa[n]; pend[n].data = dd[n];
                end
        end
        @(posedge Clk);
        #1;
        chk("We", We, e_we);
        chk("Gnt", Gnt, e_gnt[1:0]);
        chk("Wr", Wr, e_wr[AW-1:0]);
        chk("D", D, e_d);
        chk("Busy", Busy, pend[0].v | pend[1].v);
        if (We === 1'b1) dut_rf[Wr] = D;
        @(negedge Clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, 0, 0, '0);
    endtask

    initial begin
        Clr = 1; V0 = 0; V1 = 0; A0 = '0; A1 = '0; D0 = '0; D1 = '0;
        for (int i = 0; i < 32; i++) begin exp_rf[i] = '0; dut_rf[i] = '0; end
        model_reset();
        @(negedge Clk);

        // reset, then ready must come back
        cycle(1, 0, 0, '0, 0, 0, '0);
        idle(1);

        // single write
        cycle(0, 1, 3, 32'd666, 0, 0, '0);
        idle(2);
        chk("rf3_single", dut_rf[3], 32'd666);

        // contention on the same edge
        cycle(0, 1, 3, 32'd666, 1, 4, 32'h666);
        idle(3);
        chk("rf3_contend", dut_rf[3], 32'd666);
        chk("rf4_contend", dut_rf[4], 32'h666);

        // streaming from both requesters
        for (int i = 0; i < 6; i++)
            cycle(0, 1, $urandom_range(1, 31), $urandom, 1, $urandom_range(1, 31), $urandom);
        idle(3);

        // address 0 is swallowed
        cycle(0, 1, 0, 32'hFFFF_FFFF, 0, 0, '0);
        idle(2);

        // same address from both: later grant is final
        cycle(0, 1, 7, 32'hA, 1, 7, 32'hB);
        idle(3);
        chk("rf7_same", dut_rf[7], exp_rf[7]);

        // reset with both slots full drops everything
        cycle(0, 1, 9, 32'h99, 1, 10, 32'h1010);
        cycle(1, 0, 0, '0, 0, 0, '0);
        idle(3);

        // randomized traffic with occasional resets
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 39) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom);
        idle(4);
        for (int i = 0; i < 32; i++) chk($sformatf("rf%0d_final", i), dut_rf[i], exp_rf[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
